keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4×4 active-low matrix keypad and emits the debounced hex code of the pressed key. It is the input end of the hex display path: its `key` nibble feeds the seven-segment hex decoder in place of the DIP switches. A one-cycle `key_valid` strobe marks each new press.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each column is driven before sampling and advancing (≥2).
- `DEBOUNCE_CYCLES`, 240000: consecutive stable cycles required to accept a press or a release (≥2).
- `REPEAT_CYCLES`, 12000000: auto-repeat interval. Used only when `KEYPAD_REPEAT_EN` is defined.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `rows`, input, 4: keypad row lines. Asynchronous, pulled up, active-low.
- `cols`, output, 4: column drive. Active-low; exactly one bit is low at all times.
- `key`, output, 4: hex code of the last accepted key. Holds its value until the next accepted key.
- `key_valid`, output, 1: one-cycle pulse when a new key is accepted.
- `key_held`, output, 1: high from acceptance until the release is debounced.

## Operation
- `rows` passes through a 2-flop synchronizer; all logic uses the synchronized value `rs`.
- A press means exactly one bit of `rs` is low. Zero or ≥2 low bits count as no press.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- State machine:
  - SCAN: drive the current column (`cols` = ~(1<<col)). The dwell counter counts to SCAN_DIV−1. On the last dwell cycle, if a press is seen, capture row and col and go to DEBOUNCE. Otherwise advance col, wrapping 3→0.
  - DEBOUNCE: keep driving the captured column. Count cycles in which `rs` equals the captured pattern.
    - Any mismatch returns to SCAN, advancing col.
    - When the count reaches DEBOUNCE_CYCLES: `key` ← map[row][col], pulse `key_valid`, set `key_held`, go to HELD.
  - HELD: keep the column. When `rs` == 4'hF, go to RELEASE with the counter cleared.
  - RELEASE: count consecutive cycles with `rs` == 4'hF.
    - Any low bit returns to HELD. `key_valid` does not pulse.
    - When the count reaches DEBOUNCE_CYCLES: clear `key_held`, go to SCAN, advancing col.
- While in HELD or RELEASE, other columns are not scanned, so a second simultaneous key is ignored. After release, scanning resumes and can detect a key that is still down.
- Reset values, including reset mid-operation:
  - state SCAN, col 0, `cols` = 4'b1110
  - `key` = 4'h0, `key_valid` = 0, `key_held` = 0
  - all counters 0, synchronizer flops 1

## Timing
- Synchronizer latency: 2 cycles from `rows` to `rs`.
- The full scan period is 4×SCAN_DIV cycles.
- `key_valid` rises exactly DEBOUNCE_CYCLES cycles after entry to DEBOUNCE, provided `rs` stays constant. It lasts one cycle. `key` updates in the same cycle and is registered.
- `key_held` falls DEBOUNCE_CYCLES cycles after `rs` first reads 4'hF.
- Worst-case press-to-`key_valid` latency: 2 + 4×SCAN_DIV + DEBOUNCE_CYCLES cycles.
- All outputs are registered; there is no combinational path from `rows`.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter runs.
  - Every REPEAT_CYCLES cycles, `key_valid` pulses again with `key` unchanged.
  - The counter clears on entry to HELD and pauses in RELEASE. A return to HELD from RELEASE resumes it from its paused value.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_valid` per accepted press. No repeat counter is instantiated.

## Structure
- Package `keypad_pkg`:
  - state enum `scan_state_t` (SCAN, DEBOUNCE, HELD, RELEASE)
  - constant `KEY_MAP[4][4]` of 4-bit codes
  - the ROWS_IDLE = 4'hF constant
- Sub-module `row_sync`: a parameterized-width 2-flop synchronizer with synchronous reset to all ones.

## Test plan
Use SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32 unless noted.
- Reset held for 3 cycles with no keys → `cols` cycles 1110, 1101, 1011, 0111 every 4 cycles, `key_valid` never pulses, `key` = 0.
- Row1 tied low whenever col2 is driven, held 100 cycles → one `key_valid` pulse, `key` = 4'h6, `key_held` = 1, `cols` stays 1011.
- Row3/col1 press that bounces (toggles) every 3 cycles for 20 cycles, then stable → no pulse during the bounce; after stabilizing, one pulse with `key` = 4'h0.
- Release with a 5-cycle glitch back to low → `key_held` stays 1; it clears 8 cycles after the final high, then scanning resumes.
- Row0 and row2 both low on col0 → treated as no press, no pulse, scanning continues.
- With `KEYPAD_REPEAT_EN`, key A (row0/col3) held 100 cycles after acceptance → pulses at acceptance and at +32, +64 and +96 cycles, `key` = 4'hA each time. Without the macro → one pulse only.
- Reset asserted mid-DEBOUNCE → next cycle `cols` = 1110, `key_held` = 0, no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] ROWS_IDLE = 4'hF;

   // Hex code per key, indexed [row][col].
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // A press is exactly one row line pulled low.
   function automatic logic single_low(input logic [3:0] r);
      logic [3:0] low;
      low = ~r;
      return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for asynchronous row lines; resets to all ones (idle).
module row_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV        = 50000,
   parameter int unsigned DEBOUNCE_CYCLES = 240000,
   parameter int unsigned REPEAT_CYCLES   = 12000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);
   import keypad_pkg::*;

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [3:0]       rs;
   scan_state_t      state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [DIV_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cols_q, cols_d;
   logic [3:0]       key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic [3:0]       row_pat_c;
   logic             rep_fire_c;

   row_sync #(.WIDTH(4)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rs)
   );

   assign row_pat_c = ~(4'b0001 << row_q);

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   logic [REP_W-1:0] rep_q, rep_d;

   // Runs only in HELD; cleared while debouncing so each press starts fresh, paused in RELEASE.
   always_comb begin
      rep_d      = rep_q;
      rep_fire_c = 1'b0;
      if (state_q == DEBOUNCE) begin
         rep_d = '0;
      end else if (state_q == HELD) begin
         if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_d      = '0;
            rep_fire_c = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rep_q <= '0;
      else       rep_q <= rep_d;
   end
`else
   logic unused_repeat;
   assign rep_fire_c    = 1'b0;
   assign unused_repeat = (REPEAT_CYCLES == 0);
`endif

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      dwell_d     = dwell_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      unique case (state_q)
         SCAN: begin
            if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
               dwell_d = '0;
               if (single_low(rs)) begin
                  row_d   = low_index(rs);
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs != row_pat_c) begin
               state_d = SCAN;
               col_d   = col_q + 2'd1;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               key_d       = KEY_MAP[row_q][col_q];
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
               cnt_d       = '0;
               state_d     = HELD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            key_valid_d = rep_fire_c;
            if (rs == ROWS_IDLE) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // The HELD cycle that first saw idle rows is the first of the run.
            if (rs != ROWS_IDLE) begin
               state_d = HELD;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
               key_held_d = 1'b0;
               cnt_d      = '0;
               col_d      = col_q + 2'd1;
               state_d    = SCAN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
      cols_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         dwell_q     <= '0;
         cnt_q       <= '0;
         cols_q      <= 4'b1110;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         cols_q      <= cols_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign cols      = cols_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   logic [3:0] pk [4];
   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int p0;
   int n;
   logic found;

`ifdef KEYPAD_REPEAT_EN
   localparam int T3_PULSES = 3;
   localparam int T7_PULSES = 4;
`else
   localparam int T3_PULSES = 1;
   localparam int T7_PULSES = 1;
`endif

   keypad_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_CYCLES   (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // A row reads low when a pressed key sits on a currently driven column.
   always_comb begin
      for (int r = 0; r < 4; r++) rows[r] = ~|(pk[r] & ~cols);
   end

   always @(negedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

   task automatic step(input int cnt);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset and idle scan
      reset = 1'b1;
      for (int r = 0; r < 4; r++) pk[r] = 4'h0;
      step(3);
      chk("rst_cols", cols, 4'b1110);
      chk("rst_key", key, 4'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      reset = 1'b0;
      p0 = pulses;
      step(4); chk("scan_c1", cols, 4'b1101);
      step(4); chk("scan_c2", cols, 4'b1011);
      step(4); chk("scan_c3", cols, 4'b0111);
      step(4); chk("scan_wrap", cols, 4'b1110);
      chk("idle_pulses", pulses - p0, 0);
      chk("idle_key", key, 4'h0);

      // Exact press latency: key 7 (row2/col0) down through reset
      reset = 1'b1;
      pk[2][0] = 1'b1;
      step(3);
      reset = 1'b0;
      p0 = pulses;
      step(11);
      chk("deb_early_valid", key_valid, 1'b0);
      chk("deb_early_held", key_held, 1'b0);
      step(1);
      chk("deb_valid", key_valid, 1'b1);
      chk("deb_key7", key, 4'h7);
      chk("deb_held", key_held, 1'b1);
      step(1);
      chk("deb_one_cycle", key_valid, 1'b0);
      chk("deb_cols", cols, 4'b1110);
      pk[2][0] = 1'b0;
      step(9);
      chk("rel_still_held", key_held, 1'b1);
      step(1);
      chk("rel_done", key_held, 1'b0);
      chk("rel_resume_cols", cols, 4'b1101);
      chk("deb_pulses", pulses - p0, 1);

      // Key 6 (row1/col2) held 100 cycles
      p0 = pulses;
      pk[1][2] = 1'b1;
      step(15);
      chk("k6_early", key_valid, 1'b0);
      step(1);
      chk("k6_valid", key_valid, 1'b1);
      chk("k6_key", key, 4'h6);
      step(84);
      chk("k6_key_hold", key, 4'h6);
      chk("k6_held", key_held, 1'b1);
      chk("k6_cols", cols, 4'b1011);
      chk("k6_pulses", pulses - p0, T3_PULSES);
      pk[1][2] = 1'b0;
      step(10);
      chk("k6_released", key_held, 1'b0);
      chk("k6_next_col", cols, 4'b0111);

      // Bouncing key 0 (row3/col1), then stable
      step(4);
      p0 = pulses;
      for (int i = 0; i < 20; i++) begin
         pk[3][1] = ((i / 3) % 2 == 1);
         step(1);
      end
      chk("bounce_no_pulse", pulses - p0, 0);
      chk("bounce_not_held", key_held, 1'b0);
      pk[3][1] = 1'b1;
      step(28);
      chk("bounce_pulses", pulses - p0, 1);
      chk("bounce_key0", key, 4'h0);
      chk("bounce_held", key_held, 1'b1);
      chk("bounce_cols", cols, 4'b1101);

      // Release with a 5-cycle glitch back to pressed
      p0 = pulses;
      pk[3][1] = 1'b0;
      step(3);
      pk[3][1] = 1'b1;
      step(5);
      pk[3][1] = 1'b0;
      step(9);
      chk("glitch_held", key_held, 1'b1);
      step(1);
      chk("glitch_release", key_held, 1'b0);
      chk("glitch_resume_cols", cols, 4'b1011);
      chk("glitch_no_pulse", pulses - p0, 0);

      // Two rows low on col0: not a press
      p0 = pulses;
      pk[0][0] = 1'b1;
      pk[2][0] = 1'b1;
      step(40);
      chk("multi_no_pulse", pulses - p0, 0);
      chk("multi_not_held", key_held, 1'b0);
      chk("multi_cols", cols, 4'b1110);
      pk[0][0] = 1'b0;
      pk[2][0] = 1'b0;

      // Key A (row0/col3) held 100 cycles past acceptance
      p0 = pulses;
      pk[0][3] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1);
         if (key_valid === 1'b1) found = 1'b1;
      end
      chk("rpt_accept", found, 1'b1);
      chk("rpt_key", key, 4'hA);
      for (int i = 1; i <= 100; i++) begin
         step(1);
`ifdef KEYPAD_REPEAT_EN
         if (i % 32 == 0) begin
            chk("rpt_pulse", key_valid, 1'b1);
            chk("rpt_pulse_key", key, 4'hA);
         end else if (i % 32 == 31) begin
            chk("rpt_not_early", key_valid, 1'b0);
         end
`endif
      end
      chk("rpt_count", pulses - p0, T7_PULSES);
      chk("rpt_key_end", key, 4'hA);
      pk[0][3] = 1'b0;
      step(12);

      // Reset asserted mid-DEBOUNCE on col2
      p0 = pulses;
      n = 0;
      while (cols === 4'b1011 && n < 20) begin step(1); n++; end
      pk[1][2] = 1'b1;
      n = 0;
      while (cols !== 4'b1011 && n < 20) begin step(1); n++; end
      chk("mid_reach_col2", cols, 4'b1011);
      step(8);
      chk("mid_stays_col2", cols, 4'b1011);
      chk("mid_no_valid", key_valid, 1'b0);
      chk("mid_old_key", key, 4'hA);
      reset = 1'b1;
      step(1);
      chk("mid_rst_cols", cols, 4'b1110);
      chk("mid_rst_held", key_held, 1'b0);
      chk("mid_rst_valid", key_valid, 1'b0);
      chk("mid_rst_key", key, 4'h0);
      pk[1][2] = 1'b0;
      step(1);
      reset = 1'b0;
      step(20);
      chk("mid_no_pulse", pulses - p0, 0);
      chk("mid_key_zero", key, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
